// File: rtl/tx_gearbox_seq.sv
// tx_gearbox_seq: 64b/66b external-gearbox TX sequencer (TXSEQUENCE, half-select, block-read/idle scheduling).
// Latency: outputs decode combinationally from registered state; blk_rd_o/idle_ins_o also follow src_empty_i with zero latency.
// Backpressure: none accepted; an empty source on a data slot yields an idle-insert instead of a read.
// Optional: define TX_GBX_STAT_EN to add underflow_cnt_o (saturating idle-insert count) and pause_o.
module tx_gearbox_seq #(
    parameter int SEQ_MAX = 32,
    parameter int SEQ_W   = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             src_empty_i,
    output logic             blk_rd_o,
    output logic             idle_ins_o,
    output logic             half_sel_o,
    output logic             head_vld_o,
    output logic             data_vld_o,
    output logic [SEQ_W-1:0] txsequence_o,
`ifdef TX_GBX_STAT_EN
    output logic [15:0]      underflow_cnt_o,
    output logic             pause_o,
`endif
    output logic             running_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(SEQ_MAX);

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              active;

    // State and slot counters; reset parks everything at IDLE / slot 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            seq_q   <= seq_d;
        end
    end

    // Next state: a stop at phase 0 lets the current slot finish through STOP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable_i) state_d = ST_RUN;
            ST_RUN: begin
                if (!enable_i) begin
                    state_d = phase_q ? ST_IDLE : ST_STOP;
                end
            end
            ST_STOP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Slot counters advance only while staying active; landing in IDLE zeroes them.
    always_comb begin
        phase_d = 1'b0;
        seq_d   = '0;
        if (state_q == ST_RUN && state_d != ST_IDLE) begin
            phase_d = ~phase_q;
            seq_d   = seq_q;
            if (phase_q) begin
                seq_d = (seq_q == SEQ_LAST) ? '0 : seq_q + SEQ_W'(1);
            end
        end
    end

    // Output decode: pause slot carries no data; a data slot reads or idles on its first half.
    always_comb begin
        active       = (state_q == ST_RUN) || (state_q == ST_STOP);
        txsequence_o = active ? seq_q : '0;
        half_sel_o   = active & phase_q;
        data_vld_o   = active && (seq_q != SEQ_LAST);
        head_vld_o   = data_vld_o & ~phase_q;
        blk_rd_o     = head_vld_o & ~src_empty_i;
        idle_ins_o   = head_vld_o & src_empty_i;
        running_o    = (state_q == ST_RUN);
    end

`ifdef TX_GBX_STAT_EN
    logic [15:0] underflow_cnt_q;

    // Saturating count of idle substitutions; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            underflow_cnt_q <= '0;
        end else if (idle_ins_o && underflow_cnt_q != 16'hFFFF) begin
            underflow_cnt_q <= underflow_cnt_q + 16'd1;
        end
    end

    // Statistics outputs.
    always_comb begin
        underflow_cnt_o = underflow_cnt_q;
        pause_o         = active && (seq_q == SEQ_LAST);
    end
`endif

endmodule

// File: tb/tb_tx_gearbox_seq.sv
// tb_tx_gearbox_seq: directed stimulus against a slot-time model of the TX gearbox sequencer.
// Model tracks mode plus elapsed cycles since RUN entry; slot/half derive from that by division.
// Literal checks at key points pin the model; summary line reports totals.
module tb_tx_gearbox_seq;

    localparam int SEQ_MAX = 32;
    localparam int SEQ_W   = 7;
    localparam int PERIOD  = 2 * (SEQ_MAX + 1);

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             enable_i;
    logic             src_empty_i;
    logic             blk_rd_o, idle_ins_o, half_sel_o, head_vld_o, data_vld_o, running_o;
    logic [SEQ_W-1:0] txsequence_o;
`ifdef TX_GBX_STAT_EN
    logic [15:0]      underflow_cnt_o;
    logic             pause_o;
`endif

    tx_gearbox_seq #(.SEQ_MAX(SEQ_MAX), .SEQ_W(SEQ_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .src_empty_i  (src_empty_i),
        .blk_rd_o     (blk_rd_o),
        .idle_ins_o   (idle_ins_o),
        .half_sel_o   (half_sel_o),
        .head_vld_o   (head_vld_o),
        .data_vld_o   (data_vld_o),
        .txsequence_o (txsequence_o),
`ifdef TX_GBX_STAT_EN
        .underflow_cnt_o (underflow_cnt_o),
        .pause_o         (pause_o),
`endif
        .running_o    (running_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=idle 1=run 2=stop, t = cycles elapsed since entering RUN.
    int m_mode = 0;
    int m_t    = 0;
    int m_uf   = 0;

    function automatic int m_seq();
        return (m_mode != 0) ? (m_t % PERIOD) / 2 : 0;
    endfunction
    function automatic int m_ph();
        return (m_mode != 0) ? (m_t % 2) : 0;
    endfunction
    function automatic int m_head();
        return (m_mode != 0 && m_seq() != SEQ_MAX && m_ph() == 0) ? 1 : 0;
    endfunction

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_mode = 0; m_t = 0; m_uf = 0;
        end else begin
            if (m_head() == 1 && src_empty_i && m_uf < 65535) m_uf++;
            case (m_mode)
                0: if (enable_i) begin m_mode = 1; m_t = 0; end
                1: begin
                    if (!enable_i && (m_t % 2) == 1) begin
                        m_mode = 0; m_t = 0;
                    end else begin
                        if (!enable_i) m_mode = 2;
                        m_t++;
                    end
                end
                default: begin m_mode = 0; m_t = 0; end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (chk_en) begin
            int s, dv;
            s  = m_seq();
            dv = (m_mode != 0 && s != SEQ_MAX) ? 1 : 0;
            chk("m_txseq",   int'(txsequence_o), s);
            chk("m_half",    int'(half_sel_o), m_ph());
            chk("m_datavld", int'(data_vld_o), dv);
            chk("m_headvld", int'(head_vld_o), m_head());
            chk("m_blkrd",   int'(blk_rd_o), (m_head() == 1 && !src_empty_i) ? 1 : 0);
            chk("m_idleins", int'(idle_ins_o), (m_head() == 1 && src_empty_i) ? 1 : 0);
            chk("m_running", int'(running_o), (m_mode == 1) ? 1 : 0);
`ifdef TX_GBX_STAT_EN
            chk("m_uf_cnt",  int'(underflow_cnt_o), m_uf);
            chk("m_pause",   int'(pause_o), (m_mode != 0 && s == SEQ_MAX) ? 1 : 0);
`endif
        end
    end

    // Advance to the negedge of the cycle showing slot s, half p.
    task automatic wait_slot(input int s, input int p);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (int'(txsequence_o) == s && int'(half_sel_o) == p) return;
        end
        chk("wait_slot_timeout", 0, 1);
    endtask

    task automatic drive(input logic r, input logic e, input logic m);
        @(posedge clk_i);
        #1;
        rst_i = r; enable_i = e; src_empty_i = m;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_blk"},  int'(blk_rd_o), 0);
        chk({tag, "_idle"}, int'(idle_ins_o), 0);
        chk({tag, "_half"}, int'(half_sel_o), 0);
        chk({tag, "_head"}, int'(head_vld_o), 0);
        chk({tag, "_dv"},   int'(data_vld_o), 0);
        chk({tag, "_seq"},  int'(txsequence_o), 0);
        chk({tag, "_run"},  int'(running_o), 0);
    endtask

    initial begin
        int cnt, bad;
        rst_i = 1'b1; enable_i = 1'b1; src_empty_i = 1'b0;
        @(posedge clk_i);
        chk_en = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk_all_zero("rst");
        @(negedge clk_i);
        chk("first_run", int'(running_o), 1);
        chk("first_seq", int'(txsequence_o), 0);
        chk("first_half", int'(half_sel_o), 0);
        chk("first_head", int'(head_vld_o), 1);

        // Steady run: three full periods from the first RUN cycle.
        cnt = 0; bad = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            if (i > 0) @(negedge clk_i);
            if (blk_rd_o) cnt++;
            if (blk_rd_o && (txsequence_o == 7'd32 || half_sel_o)) bad++;
        end
        chk("blk_per_3_periods", cnt, 3 * SEQ_MAX);
        chk("blk_bad_position", bad, 0);

        // Underflow on slot 5, normal read on slot 6.
        wait_slot(4, 1);
        drive(0, 1, 1);
        @(negedge clk_i);
        chk("uf_seq", int'(txsequence_o), 5);
        chk("uf_idle", int'(idle_ins_o), 1);
        chk("uf_blk", int'(blk_rd_o), 0);
        drive(0, 1, 1);
        drive(0, 1, 0);
        @(negedge clk_i);
        chk("uf_next_seq", int'(txsequence_o), 6);
        chk("uf_next_blk", int'(blk_rd_o), 1);

        // Stop sampled at phase 0 of slot 10.
        wait_slot(9, 1);
        drive(0, 0, 0);
        @(negedge clk_i);
        chk("stop_ph0_seq", int'(txsequence_o), 10);
        @(negedge clk_i);
        chk("stop_half", int'(half_sel_o), 1);
        chk("stop_dv", int'(data_vld_o), 1);
        chk("stop_seq", int'(txsequence_o), 10);
        chk("stop_run", int'(running_o), 0);
        @(negedge clk_i);
        chk("stop_idle_seq", int'(txsequence_o), 0);
        chk("stop_idle_dv", int'(data_vld_o), 0);
        drive(0, 1, 0);
        @(negedge clk_i);
        chk("reen_still_idle", int'(running_o), 0);
        @(negedge clk_i);
        chk("reen_run", int'(running_o), 1);
        chk("reen_seq", int'(txsequence_o), 0);
        chk("reen_head", int'(head_vld_o), 1);

        // Re-enable during STOP is ignored.
        wait_slot(12, 1);
        drive(0, 0, 0);
        drive(0, 1, 0);
        @(negedge clk_i);
        chk("stopre_run", int'(running_o), 0);
        chk("stopre_seq", int'(txsequence_o), 13);
        chk("stopre_half", int'(half_sel_o), 1);
        @(negedge clk_i);
        chk("stopre_idle_run", int'(running_o), 0);
        chk("stopre_idle_seq", int'(txsequence_o), 0);
        @(negedge clk_i);
        chk("stopre_restart", int'(running_o), 1);

        // Stop sampled at phase 1 goes straight to IDLE.
        wait_slot(14, 0);
        drive(0, 0, 0);
        @(negedge clk_i);
        chk("stop1_half", int'(half_sel_o), 1);
        chk("stop1_run", int'(running_o), 1);
        @(negedge clk_i);
        chk("stop1_idle_run", int'(running_o), 0);
        chk("stop1_idle_seq", int'(txsequence_o), 0);
        drive(0, 1, 0);

        // Stop during the pause slot, phase 0 then phase 1.
        wait_slot(31, 1);
        drive(0, 0, 0);
        @(negedge clk_i);
        chk("pz0_seq", int'(txsequence_o), SEQ_MAX);
        chk("pz0_dv", int'(data_vld_o), 0);
        @(negedge clk_i);
        chk("pz0_stop_seq", int'(txsequence_o), SEQ_MAX);
        chk("pz0_stop_half", int'(half_sel_o), 1);
        chk("pz0_stop_blk", int'(blk_rd_o), 0);
        chk("pz0_stop_run", int'(running_o), 0);
        @(negedge clk_i);
        chk("pz0_idle_seq", int'(txsequence_o), 0);
        drive(0, 1, 0);
        wait_slot(SEQ_MAX, 0);
        drive(0, 0, 0);
        @(negedge clk_i);
        chk("pz1_run", int'(running_o), 1);
        @(negedge clk_i);
        chk("pz1_idle_run", int'(running_o), 0);
        drive(0, 1, 0);

        // Reset mid-run at slot 20, phase 1.
        wait_slot(20, 0);
        drive(1, 1, 0);
        @(negedge clk_i);
        chk("rstmid_pre_seq", int'(txsequence_o), 20);
        @(negedge clk_i);
        chk_all_zero("rstmid");
        drive(0, 1, 0);

`ifdef TX_GBX_STAT_EN
        // Three underflow slots, then pause occupancy over one period.
        wait_slot(2, 1);
        drive(0, 1, 1);
        repeat (5) drive(0, 1, 1);
        drive(0, 1, 0);
        @(negedge clk_i);
        chk("stat_uf3", int'(underflow_cnt_o), 3);
        cnt = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk_i);
            if (pause_o) cnt++;
        end
        chk("stat_pause_per_period", cnt, 2);
`endif

        repeat (5) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
